// File: rtl/mem_stall_responder_pkg.sv
// Shared encodings for the multi-cycle data-memory responder.
package mem_stall_responder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Width of the latency down-counter (LATENCY up to 15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_stall_responder_if.sv
// Pipeline-to-memory request bus: the pipeline is the master, the responder the slave.
interface mem_stall_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  modport master (
    output addr, data_in, rd, wr,
    input  data_out, done, stall, err
  );

  modport slave (
    input  addr, data_in, rd, wr,
    output data_out, done, stall, err
  );
endinterface

// File: rtl/mem_stall_responder_array.sv
// Word storage: single port, write on the clock edge, combinational read.
module mem_word_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);
  logic [15:0] mem_q [2**ADDR_BITS];

  // Contents are never reset; only an explicit write changes a word.
  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  assign rdata = mem_q[idx];
endmodule

// File: rtl/mem_stall_responder.sv
// Multi-cycle data-memory responder: one request at a time, stall while busy,
// done pulse with read data LATENCY cycles after acceptance.
import mem_stall_responder_pkg::*;

module mem_stall_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stall_responder_if.slave  bus
);
  // cnt holds the cycles still to wait including the completion edge; the
  // access completes on the edge where it would step from 1 to 0.
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam bit               IMMEDIATE = (LATENCY == 1);

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_BITS-1:0]  waddr_q;
  logic [15:0]           wdata_q;
  op_t                   op_q;
  logic [15:0]           data_out_q;
  logic                  done_q;
  logic                  stall_q;
  logic                  err_q;

  logic                  req_legal;
  logic                  req_illegal;
  logic                  finish_now;
  op_t                   op_now;
  logic [ADDR_BITS-1:0]  idx_now;
  logic [15:0]           wdata_now;
  logic                  mem_we;
  logic [15:0]           mem_rdata;
  logic                  unused_addr_bits;

  assign req_legal   = (bus.rd ^ bus.wr) && !bus.addr[0];
  assign req_illegal = (bus.rd | bus.wr) && !req_legal;

  // With LATENCY=1 the access happens on the accept edge itself, so the
  // memory port sees the live bus in IDLE and the captured request in BUSY.
  assign finish_now = (state_q == IDLE && req_legal && IMMEDIATE) ||
                      (state_q == BUSY && cnt_q == CNT_W'(1));
  assign op_now     = (state_q == IDLE) ? (bus.wr ? OP_WR : OP_RD) : op_q;
  assign idx_now    = (state_q == IDLE) ? bus.addr[ADDR_BITS:1] : waddr_q;
  assign wdata_now  = (state_q == IDLE) ? bus.data_in : wdata_q;
  assign mem_we     = finish_now && (op_now == OP_WR) && !rst;

  // Upper byte-address bits wrap and are deliberately ignored.
  assign unused_addr_bits = ^bus.addr[15:ADDR_BITS+1];

  mem_word_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx_now),
    .wdata (wdata_now),
    .rdata (mem_rdata)
  );

  // Request FSM with capture registers, latency counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (finish_now) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        stall_q <= 1'b0;
        done_q  <= 1'b1;
        if (op_now == OP_RD) data_out_q <= mem_rdata;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_legal) begin
              waddr_q <= bus.addr[ADDR_BITS:1];
              wdata_q <= bus.data_in;
              op_q    <= bus.wr ? OP_WR : OP_RD;
              cnt_q   <= CNT_LOAD;
              stall_q <= 1'b1;
              state_q <= BUSY;
            end else if (req_illegal) begin
              err_q <= 1'b1;
            end
          end
          BUSY: begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.done     = done_q;
  assign bus.stall    = stall_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_stall_responder.sv
// Bench for mem_stall_responder: directed vector table, reset/LATENCY=1
// sequences and randomized requests checked against a behavioural model.
module tb_mem_stall_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stall_responder_if if4();
  mem_stall_responder_if if1();

  mem_stall_responder #(.LATENCY(4), .ADDR_BITS(10)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  mem_stall_responder #(.LATENCY(1), .ADDR_BITS(10)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model: word memory keyed by word index, last read data.
  logic [15:0] mem_m [int];
  logic [15:0] dout_m = 16'h0000;
  logic [15:0] known_q [$];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    bit          inject;
    bit          exp_err;
    logic [15:0] exp_dout;
  } vec_t;
  vec_t tbl [15];

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%04h required 0x%04h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Apply the memory rules to the model and report the expected outcome.
  task automatic model_apply(input bit rd, input bit wr, input logic [15:0] addr,
                             input logic [15:0] data, output bit exp_err,
                             output logic [15:0] exp_dout);
    bit legal = (rd ^ wr) && !addr[0];
    int idx   = int'(addr[10:1]);
    if (legal) begin
      if (wr) begin
        mem_m[idx] = data;
        known_q.push_back(addr & 16'h07FE);
      end else begin
        dout_m = mem_m[idx];
      end
    end
    exp_err  = !legal && (rd | wr);
    exp_dout = dout_m;
  endtask

  // Present one request to the LATENCY=4 responder in the current cycle and
  // follow it to completion; returns in the done cycle (or one cycle past err).
  task automatic transact(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] data, input bit inject,
                          input bit exp_err, input logic [15:0] exp_dout);
    int fails_before = total_cnt - pass_cnt;
    if4.rd = rd; if4.wr = wr; if4.addr = addr; if4.data_in = data;
    tick;
    if4.rd = 1'b0; if4.wr = 1'b0;
    if (exp_err) begin
      check("err_pulse", {15'd0, if4.err}, 16'd1);
      check("err_stall", {15'd0, if4.stall}, 16'd0);
      check("err_done", {15'd0, if4.done}, 16'd0);
      tick;
      check("err_one_cycle", {15'd0, if4.err}, 16'd0);
    end else begin
      for (int k = 1; k < 4; k++) begin
        if (inject) begin
          if4.wr = 1'b1; if4.addr = addr ^ 16'h0002; if4.data_in = 16'hFFFF;
        end
        check("busy_stall", {15'd0, if4.stall}, 16'd1);
        check("busy_done", {15'd0, if4.done}, 16'd0);
        check("busy_err", {15'd0, if4.err}, 16'd0);
        tick;
      end
      if4.rd = 1'b0; if4.wr = 1'b0;
      check("done_pulse", {15'd0, if4.done}, 16'd1);
      check("done_stall", {15'd0, if4.stall}, 16'd0);
      check("done_err", {15'd0, if4.err}, 16'd0);
      check("data_out", if4.data_out, exp_dout);
    end
    $display("txn rd=%0d wr=%0d addr=%04h data=%04h inj=%0d err=%0d dout=%04h -> %s",
             rd, wr, addr, data, inject, exp_err, exp_dout,
             ((total_cnt - pass_cnt) == fails_before) ? "ok" : "bad");
  endtask

  initial begin
    bit          e_err;
    logic [15:0] e_dout;

    if4.rd = 0; if4.wr = 0; if4.addr = 0; if4.data_in = 0;
    if1.rd = 0; if1.wr = 0; if1.addr = 0; if1.data_in = 0;

    // Directed vectors: {rd, wr, addr, data, inject, exp_err, exp_dout}
    tbl[0]  = '{0, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000};
    tbl[1]  = '{1, 0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF};
    tbl[2]  = '{0, 1, 16'h0020, 16'h1111, 0, 0, 16'hBEEF};
    tbl[3]  = '{1, 1, 16'h0020, 16'h2222, 0, 1, 16'hBEEF};
    tbl[4]  = '{1, 0, 16'h0021, 16'h0000, 0, 1, 16'hBEEF};
    tbl[5]  = '{0, 1, 16'h0023, 16'h3333, 0, 1, 16'hBEEF};
    tbl[6]  = '{1, 0, 16'h0020, 16'h0000, 0, 0, 16'h1111};
    tbl[7]  = '{0, 1, 16'h0042, 16'h7777, 0, 0, 16'h1111};
    tbl[8]  = '{0, 1, 16'h0040, 16'h1234, 1, 0, 16'h1111};
    tbl[9]  = '{1, 0, 16'h0042, 16'h0000, 0, 0, 16'h7777};
    tbl[10] = '{1, 0, 16'h0040, 16'h0000, 0, 0, 16'h1234};
    tbl[11] = '{0, 1, 16'h0002, 16'hAAAA, 0, 0, 16'h1234};
    tbl[12] = '{1, 0, 16'h0802, 16'h0000, 0, 0, 16'hAAAA};
    tbl[13] = '{0, 1, 16'h0060, 16'h3C3C, 0, 0, 16'hAAAA};
    tbl[14] = '{1, 0, 16'h0060, 16'h0000, 0, 0, 16'h3C3C};

    // Reset state of both builds.
    tick;
    tick;
    check("rst_data_out", if4.data_out, 16'h0000);
    check("rst_done", {15'd0, if4.done}, 16'd0);
    check("rst_stall", {15'd0, if4.stall}, 16'd0);
    check("rst_err", {15'd0, if4.err}, 16'd0);
    check("rst_l1_data_out", if1.data_out, 16'h0000);
    rst = 1'b0;

    // Directed table; consecutive entries are issued back-to-back in the done cycle.
    foreach (tbl[i]) begin
      model_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, e_err, e_dout);
      transact(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].inject,
               tbl[i].exp_err, tbl[i].exp_dout);
    end

    // Reset two cycles into a write aborts it.
    if4.wr = 1'b1; if4.addr = 16'h0060; if4.data_in = 16'h5555;
    tick;
    if4.wr = 1'b0;
    check("abort_stall_up", {15'd0, if4.stall}, 16'd1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_stall", {15'd0, if4.stall}, 16'd0);
    check("abort_done", {15'd0, if4.done}, 16'd0);
    check("abort_data_out", if4.data_out, 16'h0000);
    $display("txn reset during write 0060<-5555");
    dout_m = 16'h0000;
    tick;
    check("abort_no_late_done", {15'd0, if4.done}, 16'd0);
    model_apply(1'b1, 1'b0, 16'h0060, 16'h0000, e_err, e_dout);
    transact(1'b1, 1'b0, 16'h0060, 16'h0000, 1'b0, e_err, e_dout);

    // Randomized requests against the model.
    for (int n = 0; n < 40; n++) begin
      bit          rd, wr, inj;
      logic [15:0] a, d;
      int          op = int'($urandom_range(0, 5));
      d   = 16'($urandom);
      inj = ($urandom_range(0, 3) == 0);
      case (op)
        0, 1: begin rd = 0; wr = 1; a = 16'($urandom) & 16'hFFFE; end
        2, 3: begin
          rd = 1; wr = 0;
          a  = known_q[$urandom_range(0, known_q.size() - 1)] |
               16'($urandom_range(0, 31) << 11);
        end
        4: begin rd = 1; wr = 1; a = 16'($urandom) & 16'hFFFE; end
        default: begin
          rd = $urandom_range(0, 1); wr = !rd; a = 16'($urandom) | 16'h0001;
        end
      endcase
      model_apply(rd, wr, a, d, e_err, e_dout);
      transact(rd, wr, a, d, inj, e_err, e_dout);
      if ($urandom_range(0, 3) == 0) tick;
    end

    // LATENCY=1 build: write then read with an idle cycle between.
    for (int i = 0; i < 3; i++) begin
      logic [15:0] v = 16'h9A00 + 16'(i);
      if1.wr = 1'b1; if1.addr = 16'h0004; if1.data_in = v;
      tick;
      if1.wr = 1'b0;
      check("l1_wr_done", {15'd0, if1.done}, 16'd1);
      check("l1_wr_stall", {15'd0, if1.stall}, 16'd0);
      tick;
      check("l1_idle_done", {15'd0, if1.done}, 16'd0);
      if1.rd = 1'b1; if1.addr = (i == 1) ? 16'h0804 : 16'h0004;
      tick;
      if1.rd = 1'b0;
      check("l1_rd_done", {15'd0, if1.done}, 16'd1);
      check("l1_rd_stall", {15'd0, if1.stall}, 16'd0);
      check("l1_rd_data", if1.data_out, v);
      tick;
      check("l1_hold_done", {15'd0, if1.done}, 16'd0);
      check("l1_hold_data", if1.data_out, v);
      $display("txn L1 write/read 0004 data=%04h", v);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
